// File: rtl/upi_bank_responder.sv
// UPI payment responder: accepts a payment request, waits a fixed authorisation
// latency, then approves or declines against the wallet balance.
module upi_bank_responder #(
  parameter int unsigned AUTH_CYCLES  = 8,
  parameter logic [7:0]  INIT_BALANCE = 8'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pay_req,
  input  logic [7:0] pay_amount,
  input  logic       pay_cancel,
  input  logic       bal_load,
  input  logic [7:0] bal_in,
  output logic       pay_done,
  output logic       upi_success,
  output logic       upi_busy,
  output logic [7:0] balance,
  output logic [7:0] txn_id,
  output logic       req_drop
);

  typedef enum logic [1:0] {IDLE, AUTH, RESP} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(AUTH_CYCLES - 1);

  state_t     state;
  logic [7:0] count;
  logic [7:0] amount;
  logic       approve;

  // A zero amount is declined; amount <= balance guarantees no underflow.
  assign approve = (amount != 8'd0) && (amount <= balance);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= 8'd0;
      amount      <= 8'd0;
      pay_done    <= 1'b0;
      upi_success <= 1'b0;
      upi_busy    <= 1'b0;
      req_drop    <= 1'b0;
      balance     <= INIT_BALANCE;
      txn_id      <= 8'd0;
    end else begin
      pay_done    <= 1'b0;
      upi_success <= 1'b0;
      req_drop    <= 1'b0;
      case (state)
        IDLE: begin
          if (bal_load) begin
            balance <= bal_in;
          end
          if (pay_req) begin
            amount   <= pay_amount;
            count    <= CNT_LOAD;
            state    <= AUTH;
            upi_busy <= 1'b1;
          end
        end
        AUTH: begin
          req_drop <= pay_req;
          // Cancel wins even on the final authorisation cycle.
          if (pay_cancel) begin
            state    <= RESP;
            pay_done <= 1'b1;
          end else if (count == 8'd0) begin
            state    <= RESP;
            pay_done <= 1'b1;
            if (approve) begin
              upi_success <= 1'b1;
              balance     <= balance - amount;
              txn_id      <= txn_id + 8'd1;
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        RESP: begin
          req_drop <= pay_req;
          state    <= IDLE;
          upi_busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          upi_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_upi_bank_responder.sv
// Directed bench for upi_bank_responder: vector table of transactions plus
// hand-written sequences for collisions, mid-transaction reset and txn_id wrap.
module tb_upi_bank_responder;

  localparam int AUTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       pay_req;
  logic [7:0] pay_amount;
  logic       pay_cancel;
  logic       bal_load;
  logic [7:0] bal_in;
  logic       pay_done;
  logic       upi_success;
  logic       upi_busy;
  logic [7:0] balance;
  logic [7:0] txn_id;
  logic       req_drop;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ld;
    logic [7:0] ld_val;
    logic [7:0] amt;
    int         cancel_at;
    logic       exp_succ;
    logic [7:0] exp_bal;
    logic [7:0] exp_txn;
    string      tag;
  } vec_t;

  vec_t vecs[9];

  upi_bank_responder #(.AUTH_CYCLES(AUTH), .INIT_BALANCE(8'd100)) dut (
    .clk(clk), .rst(rst), .pay_req(pay_req), .pay_amount(pay_amount),
    .pay_cancel(pay_cancel), .bal_load(bal_load), .bal_in(bal_in),
    .pay_done(pay_done), .upi_success(upi_success), .upi_busy(upi_busy),
    .balance(balance), .txn_id(txn_id), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One full transaction; cancel_at is the AUTH cycle (1-based) carrying pay_cancel, 0 for none.
  task automatic applyStimulus(input logic ld, input logic [7:0] ld_val, input logic [7:0] amt,
                               input int cancel_at, input logic exp_succ,
                               input logic [7:0] exp_bal, input logic [7:0] exp_txn,
                               input string tag);
    int lat;
    int exp_lat;
    bit seen;
    exp_lat = (cancel_at > 0) ? cancel_at + 1 : AUTH + 1;
    bal_load   = ld;
    bal_in     = ld_val;
    pay_req    = 1'b1;
    pay_amount = amt;
    step();
    bal_load = 1'b0;
    pay_req  = 1'b0;
    checkOutput({tag, " busy"}, 32'(upi_busy), 32'd1);
    seen = 1'b0;
    lat  = 0;
    for (int i = 1; i <= AUTH + 5; i++) begin
      if (!seen) begin
        if (pay_done) begin
          seen = 1'b1;
          lat  = i;
        end else begin
          pay_cancel = (i == cancel_at);
          step();
          pay_cancel = 1'b0;
        end
      end
    end
    checkOutput({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, " success"}, 32'(upi_success), 32'(exp_succ));
      checkOutput({tag, " balance"}, 32'(balance), 32'(exp_bal));
      checkOutput({tag, " txn_id"}, 32'(txn_id), 32'(exp_txn));
      step();
      checkOutput({tag, " done_pulse_end"}, 32'(pay_done), 32'd0);
      checkOutput({tag, " idle_busy"}, 32'(upi_busy), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{1'b0, 8'd0,   8'd30,  0, 1'b1, 8'd70, 8'd1, "approve30"};
    vecs[1] = '{1'b0, 8'd0,   8'd80,  0, 1'b0, 8'd70, 8'd1, "insufficient80"};
    vecs[2] = '{1'b0, 8'd0,   8'd0,   0, 1'b0, 8'd70, 8'd1, "zero_amount"};
    vecs[3] = '{1'b0, 8'd0,   8'd10,  4, 1'b0, 8'd70, 8'd1, "cancel_mid"};
    vecs[4] = '{1'b0, 8'd0,   8'd10,  8, 1'b0, 8'd70, 8'd1, "cancel_last"};
    vecs[5] = '{1'b0, 8'd0,   8'd70,  0, 1'b1, 8'd0,  8'd2, "exact_balance"};
    vecs[6] = '{1'b1, 8'd200, 8'd150, 0, 1'b1, 8'd50, 8'd3, "load_and_req"};
    vecs[7] = '{1'b0, 8'd0,   8'd51,  0, 1'b0, 8'd50, 8'd3, "one_over"};
    vecs[8] = '{1'b1, 8'd0,   8'd1,   0, 1'b0, 8'd0,  8'd3, "load_zero"};

    rst = 1'b1; pay_req = 1'b0; pay_amount = 8'd0; pay_cancel = 1'b0;
    bal_load = 1'b0; bal_in = 8'd0;
    step();
    step();
    checkOutput("reset pay_done", 32'(pay_done), 32'd0);
    checkOutput("reset upi_busy", 32'(upi_busy), 32'd0);
    checkOutput("reset balance", 32'(balance), 32'd100);
    checkOutput("reset txn_id", 32'(txn_id), 32'd0);
    rst = 1'b0;
    // pay_cancel in IDLE has no effect
    pay_cancel = 1'b1;
    step();
    pay_cancel = 1'b0;
    checkOutput("idle_cancel busy", 32'(upi_busy), 32'd0);
    checkOutput("idle_cancel pay_done", 32'(pay_done), 32'd0);

    foreach (vecs[k])
      applyStimulus(vecs[k].ld, vecs[k].ld_val, vecs[k].amt, vecs[k].cancel_at,
                    vecs[k].exp_succ, vecs[k].exp_bal, vecs[k].exp_txn, vecs[k].tag);

    // Collisions during AUTH: second request dropped, top-up ignored.
    bal_load = 1'b1; bal_in = 8'd100;
    step();
    bal_load = 1'b0;
    checkOutput("topup balance", 32'(balance), 32'd100);
    pay_req = 1'b1; pay_amount = 8'd20;
    step();
    pay_req = 1'b0;
    step();
    pay_req = 1'b1; pay_amount = 8'd90; bal_load = 1'b1; bal_in = 8'd200;
    step();
    pay_req = 1'b0; bal_load = 1'b0;
    checkOutput("collide req_drop", 32'(req_drop), 32'd1);
    checkOutput("collide bal_ignored", 32'(balance), 32'd100);
    step();
    checkOutput("collide req_drop_end", 32'(req_drop), 32'd0);
    seen = 1'b0; lat = 4;
    for (int i = 0; i < 12; i++) begin
      if (!seen) begin
        if (pay_done) seen = 1'b1;
        else begin step(); lat++; end
      end
    end
    checkOutput("collide done_seen", 32'(seen), 32'd1);
    checkOutput("collide latency", 32'(lat), 32'(AUTH + 1));
    checkOutput("collide success", 32'(upi_success), 32'd1);
    checkOutput("collide balance", 32'(balance), 32'd80);
    checkOutput("collide txn_id", 32'(txn_id), 32'd4);
    step();

    // Reset in the middle of AUTH aborts silently.
    pay_req = 1'b1; pay_amount = 8'd5;
    step();
    pay_req = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midrst pay_done", 32'(pay_done), 32'd0);
    checkOutput("midrst upi_busy", 32'(upi_busy), 32'd0);
    checkOutput("midrst upi_success", 32'(upi_success), 32'd0);
    checkOutput("midrst req_drop", 32'(req_drop), 32'd0);
    checkOutput("midrst balance", 32'(balance), 32'd100);
    checkOutput("midrst txn_id", 32'(txn_id), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < AUTH + 4; i++) begin
      if (pay_done) seen = 1'b1;
      step();
    end
    checkOutput("midrst no_done", 32'(seen), 32'd0);

    // 256 approvals of amount 1 with top-ups: txn_id wraps back to 0.
    for (int n = 1; n <= 256; n++)
      applyStimulus(1'b1, 8'd255, 8'd1, 0, 1'b1, 8'd254, 8'(n), "wrap");
    checkOutput("wrap final txn_id", 32'(txn_id), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/upi_bank_responder.md
UPI_BANK_RESPONDER -- requirements
Module: upi_bank_responder

Interface
REQ-001 Parameter: AUTH_CYCLES, 8, authorisation latency in cycles from request acceptance to response (legal range 1..255).
REQ-002 Parameter: INIT_BALANCE, 8'd100, wallet balance loaded at reset.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pay_req  input  1  payment request strobe from the vending controller.
REQ-006 pay_amount  input  8  amount requested, sampled with pay_req.
REQ-007 pay_cancel  input  1  abort of the transaction in progress.
REQ-008 bal_load  input  1  wallet top-up strobe.
REQ-009 bal_in  input  8  new balance value, sampled with bal_load.
REQ-010 pay_done  output  1  one-cycle completion pulse.
REQ-011 upi_success  output  1  valid with pay_done: 1 means approved, 0 means declined or cancelled.
REQ-012 upi_busy  output  1  high while a transaction is in progress.
REQ-013 balance  output  8  current wallet balance.
REQ-014 txn_id  output  8  count of approved transactions; wraps 255 to 0.
REQ-015 req_drop  output  1  one-cycle pulse when pay_req arrives while busy.

Function
REQ-016 The FSM SHALL have three states: IDLE, AUTH and RESP.
REQ-017 IDLE to AUTH: on pay_req=1, the block latches pay_amount, loads the cycle counter with AUTH_CYCLES-1 and asserts upi_busy on the next cycle.
REQ-018 AUTH: the counter decrements each cycle; on the cycle the counter equals 0, the FSM goes to RESP.
REQ-019 RESP lasts exactly one cycle and asserts pay_done, then returns to IDLE. Request-to-pay_done latency SHALL be AUTH_CYCLES+1 cycles.
REQ-020 Approval rule, evaluated on AUTH-to-RESP: approve if latched amount != 0 and amount <= balance; otherwise decline.
REQ-021 On approval, the block sets upi_success=1 in RESP, reduces balance by the amount and increments txn_id; both registers update on the RESP-entry edge.
REQ-022 On decline, upi_success=0 in RESP; balance and txn_id are unchanged.
REQ-023 pay_cancel=1 in AUTH sends the FSM directly to RESP with upi_success=0; balance and txn_id are unchanged. pay_cancel is ignored in IDLE and RESP.
REQ-024 pay_req in AUTH or RESP is ignored (latched amount unchanged) and req_drop pulses for one cycle.
REQ-025 bal_load is accepted only in IDLE; in AUTH or RESP it is ignored.
REQ-026 bal_load and pay_req in the same IDLE cycle: the balance is loaded and the request is accepted; approval uses the loaded value.
REQ-027 pay_cancel on the same cycle as the counter reaching 0 takes priority; the result is a decline.
REQ-028 upi_busy = (state != IDLE); upi_success is 0 outside RESP.
REQ-029 Balance arithmetic SHALL be unsigned 8-bit and can never underflow, because of REQ-020.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, pay_done=0, upi_success=0, upi_busy=0, req_drop=0, balance=INIT_BALANCE, txn_id=0, and clears the counter and latched amount.
REQ-031 Reset mid-transaction aborts it with no pay_done pulse; rst has priority over every other input.

Verification
REQ-032 Approved payment: reset, pay_req with pay_amount=30 -> pay_done and upi_success=1 exactly 9 cycles later (AUTH_CYCLES=8), balance=70, txn_id=1.
REQ-033 Insufficient funds: balance=70, pay_amount=80 -> pay_done with upi_success=0, balance stays 70, txn_id unchanged. Also pay_amount=0 -> declined.
REQ-034 Cancel: pay_req amount=10, pay_cancel on the 4th AUTH cycle -> pay_done with upi_success=0 on the next cycle, balance unchanged. Also pay_cancel on the final AUTH cycle -> declined.
REQ-035 Busy collisions: pay_req during AUTH -> req_drop pulse and original amount processed. bal_load=200 during AUTH -> ignored. bal_load=200 with pay_req amount=150 in IDLE -> approved, balance=50.
REQ-036 Wrap and reset: bal_load=255 and 256 approved payments of amount 0 are not possible, so instead drive txn_id from 255 with repeated approvals of amount 1 after top-ups -> txn_id reads 0. Assert rst mid-AUTH -> no pay_done, and all outputs at reset values on the next cycle.
